arithm_seq: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle ALU arithmetic unit. It executes add/sub in one cycle and runs multiply, divide and remainder iteratively, so the datapath no longer needs a combinational `*`, `/` or `%`. It adds signed/unsigned operation, defined divide-by-zero behaviour and a valid/ready handshake. It sits in the execute stage next to the logic/shift units, and the core stalls on `i_ready`/`o_valid`.

---
 rtl/arithm_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_arithm_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arithm_seq.sv
// arithm_seq: multi-cycle integer arithmetic unit for the execute stage.
// Add/sub finish in one registered cycle; mul/div/rem iterate one bit per
// cycle (shift-add multiply, restoring divide) with sign fix-up at the end.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_valid/i_ready request handshake (ready only in IDLE)
//   arithm_sel      00? add/sub, 010 mul lo, 011 mul hi, 100 div, 101 rem
//   i_signed        two's-complement mode for mul/div/rem
//   first_op        operand A
//   second_op       operand B
//   o_data, o_valid result and its one-cycle strobe
//   ovf, cf, dz     overflow, carry/no-borrow, divide-by-zero flags
module arithm_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [2:0]       arithm_sel,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] first_op,
    input  logic [WIDTH-1:0] second_op,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             ovf,
    output logic             cf,
    output logic             dz
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_MULL = 3'b010;
    localparam logic [2:0] OP_MULH = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_REM  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               a_neg_q;
    logic               bz_q;
    logic               pend;

    logic accept;
    logic is_long;
    logic last_iter;

    assign accept    = i_valid && i_ready;
    assign is_long   = (arithm_sel[2:1] == 2'b01) ||
                       (arithm_sel[2:1] == 2'b10);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Operand magnitudes taken at the accept edge
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = i_signed && first_op[MSB];
    assign b_neg = i_signed && second_op[MSB];
    assign a_mag = a_neg ? -first_op : first_op;
    assign b_mag = b_neg ? -second_op : second_op;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        i_ready  = 1'b0;
        unique case (state)
            S_IDLE: begin
                i_ready = 1'b1;
                if (i_valid && is_long) begin
                    state_nx = S_ITER;
                end
            end
            S_ITER: begin
                if (last_iter) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Single-cycle add/sub path, evaluated on the captured operands
    // ---------------------------------------------------------------
    logic             sub;
    logic             s_arith;
    logic             s_ovf;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;

    assign sub     = op_q[0];
    assign s_arith = (op_q[2:1] == 2'b00);
    assign bx      = b_q ^ {WIDTH{sub}};
    assign sum     = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    assign s_ovf   = (a_q[MSB] == bx[MSB]) && (sum[MSB] != a_q[MSB]);

    // ---------------------------------------------------------------
    // Iteration step. acc holds {hi, lo}:
    //   mul: hi = partial product, lo = remaining multiplier bits
    //   div: hi = partial remainder, lo = dividend / quotient bits
    // ---------------------------------------------------------------
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] mul_nx;
    logic [2*WIDTH-1:0] div_nx;

    assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
    assign mul_nx = {msum, acc[MSB:1]};

    // Remainder stays below the divisor, so the top bit of diff is a
    // clean borrow flag. With a zero divisor the result is overridden.
    assign shl    = {acc[2*WIDTH-1:WIDTH], acc[MSB]};
    assign diff   = shl - {1'b0, opb_q};
    assign ge     = !diff[WIDTH];
    assign div_nx = {ge ? diff[MSB:0] : shl[MSB:0], acc[MSB-1:0], ge};

    // ---------------------------------------------------------------
    // Sign correction and result select
    // ---------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_data;

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[MSB:0] : acc[MSB:0];
    assign rem  = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_data = '0;
        unique case (op_q)
            OP_MULL: fix_data = prod[MSB:0];
            OP_MULH: fix_data = prod[2*WIDTH-1:WIDTH];
            OP_DIV:  fix_data = bz_q ? {WIDTH{1'b1}} : quo;
            OP_REM:  fix_data = bz_q ? a_q : rem;
            default: fix_data = '0;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opb_q   <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            bz_q    <= 1'b0;
            pend    <= 1'b0;
            o_data  <= '0;
            o_valid <= 1'b0;
            ovf     <= 1'b0;
            cf      <= 1'b0;
            dz      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            pend    <= accept && !is_long;

            if (accept) begin
                a_q  <= first_op;
                b_q  <= second_op;
                op_q <= arithm_sel;
            end

            if (accept && is_long) begin
                acc     <= {{WIDTH{1'b0}}, a_mag};
                opb_q   <= b_mag;
                neg_q   <= a_neg ^ b_neg;
                a_neg_q <= a_neg;
                bz_q    <= (second_op == '0);
                cnt     <= '0;
            end

            // Add/sub/invalid accepted on the previous edge
            if (pend) begin
                o_valid <= 1'b1;
                o_data  <= s_arith ? sum[MSB:0] : '0;
                ovf     <= s_arith && s_ovf;
                cf      <= s_arith && sum[WIDTH];
                dz      <= 1'b0;
            end

            if (state == S_ITER) begin
                acc <= op_q[2] ? div_nx : mul_nx;
                cnt <= last_iter ? '0 : cnt + CNT_W'(1);
            end

            if (state == S_FIX) begin
                o_valid <= 1'b1;
                o_data  <= fix_data;
                ovf     <= 1'b0;
                cf      <= 1'b0;
                dz      <= bz_q && op_q[2];
            end
        end
    end

endmodule

// File: tb/tb_arithm_seq.sv
// tb_arithm_seq: directed and random checks of arithm_seq (WIDTH=32)
// with a result scoreboard keyed on expected arrival cycle.
module tb_arithm_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [2:0]   arithm_sel;
    logic         i_signed;
    logic [W-1:0] first_op;
    logic [W-1:0] second_op;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         ovf;
    logic         cf;
    logic         dz;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] data;
        logic [2:0]   flags;
        int           due;
    } exp_t;

    exp_t sb[$];

    arithm_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .arithm_sel (arithm_sel),
        .i_signed   (i_signed),
        .first_op   (first_op),
        .second_op  (second_op),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .ovf        (ovf),
        .cf         (cf),
        .dz         (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model built on native operators
    function automatic exp_t model(input logic [2:0] sel, input logic sgn,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        logic [W:0]  s;
        e.tag   = "";
        e.data  = '0;
        e.flags = '0;
        e.due   = 0;
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sbv = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        case (sel)
            3'b000: begin
                s       = {1'b0, a} + {1'b0, b};
                e.data  = s[W-1:0];
                e.flags = {(a[W-1] == b[W-1]) && (s[W-1] != a[W-1]),
                           s[W], 1'b0};
            end
            3'b001: begin
                e.data  = a - b;
                e.flags = {(a[W-1] != b[W-1]) && (e.data[W-1] != a[W-1]),
                           a >= b, 1'b0};
            end
            3'b010, 3'b011: begin
                p      = sa * sbv;
                e.data = sel[0] ? p[63:32] : p[31:0];
            end
            3'b100, 3'b101: begin
                if (b == '0) begin
                    e.data  = sel[0] ? a : '1;
                    e.flags = 3'b001;
                end else begin
                    q      = sa / sbv;
                    r      = sa % sbv;
                    e.data = sel[0] ? r[31:0] : q[31:0];
                end
            end
            default: e.data = '0;
        endcase
        return e;
    endfunction

    // One clock; sample 1 time unit after the edge and score o_valid
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("spurious o_valid", W'(o_valid), '0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, " data"}, o_data, e.data);
                chk({e.tag, " flags"}, W'({ovf, cf, dz}), W'(e.flags));
                chk({e.tag, " cycle"}, W'(cyc), W'(e.due));
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            chk({e.tag, " missing o_valid"}, W'(o_valid), W'(1));
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] sel,
                         input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] d,
                         input logic [2:0] fl);
        exp_t e;
        logic lng;
        lng = (sel[2:1] == 2'b01) || (sel[2:1] == 2'b10);
        chk({tag, " i_ready"}, W'(i_ready), W'(1));
        arithm_sel = sel;
        i_signed   = sgn;
        first_op   = a;
        second_op  = b;
        i_valid    = 1'b1;
        e.tag   = tag;
        e.data  = d;
        e.flags = fl;
        e.due   = cyc + (lng ? W + 2 : 2);
        sb.push_back(e);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic issue_m(input string tag, input logic [2:0] sel,
                           input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        exp_t e;
        e = model(sel, sgn, a, b);
        issue(tag, sel, sgn, a, b, e.data, e.flags);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain timeout", W'(sb.size()), '0);
            sb.delete();
        end
    endtask

    initial begin
        logic [2:0]   sel;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst        = 1'b1;
        i_valid    = 1'b0;
        arithm_sel = '0;
        i_signed   = 1'b0;
        first_op   = '0;
        second_op  = '0;

        // Reset state
        repeat (2) tick();
        chk("rst o_valid", W'(o_valid), '0);
        chk("rst o_data", o_data, '0);
        chk("rst flags", W'({ovf, cf, dz}), '0);
        chk("rst i_ready", W'(i_ready), W'(1));
        rst = 1'b0;
        tick();
        chk("post-rst i_ready", W'(i_ready), W'(1));
        chk("post-rst o_data", o_data, '0);

        // Add/sub
        issue("sub 0-1", 3'b001, 1'b0, 32'h0, 32'h1, 32'hFFFF_FFFF, 3'b000);
        drain();
        issue("add max+1", 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h1,
              32'h8000_0000, 3'b100);
        drain();
        // Back-to-back simple ops, one per cycle
        issue_m("add b2b0", 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1);
        issue_m("sub b2b1", 3'b001, 1'b0, 32'h8000_0000, 32'h1);
        issue_m("sub b2b2", 3'b001, 1'b0, 32'h5, 32'h3);
        drain();

        // Signed mul high with busy window check
        issue("mulh s", 3'b011, 1'b1, 32'hFFFF_FFFF, 32'h2,
              32'hFFFF_FFFF, 3'b000);
        for (int k = 1; k <= W; k++) begin
            tick();
            chk($sformatf("mulh s busy %0d", k), W'(i_ready), '0);
        end
        tick();
        chk("mulh s ready again", W'(i_ready), W'(1));
        drain();
        issue("mulh u", 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h2,
              32'h0000_0001, 3'b000);
        drain();

        // Division
        issue("div s -7/2", 3'b100, 1'b1, 32'hFFFF_FFF9, 32'h2,
              32'hFFFF_FFFD, 3'b000);
        drain();
        issue("rem s -7%2", 3'b101, 1'b1, 32'hFFFF_FFF9, 32'h2,
              32'hFFFF_FFFF, 3'b000);
        drain();
        issue("div u", 3'b100, 1'b0, 32'h8000_0000, 32'h3,
              32'h2AAA_AAAA, 3'b000);
        drain();
        issue("div 5/0", 3'b100, 1'b0, 32'h5, 32'h0, 32'hFFFF_FFFF, 3'b001);
        drain();
        issue("div min/-1", 3'b100, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 3'b000);
        drain();
        issue("rem 5%0", 3'b101, 1'b0, 32'h5, 32'h0, 32'h5, 3'b001);
        drain();

        // Mul, then add in the mul's o_valid cycle, then invalid op
        issue_m("b2b mul", 3'b010, 1'b0, 32'h1234_5678, 32'h0000_9ABC);
        repeat (W + 1) tick();
        issue_m("b2b add", 3'b000, 1'b0, 32'h0000_0011, 32'h0000_0022);
        issue("b2b inv", 3'b110, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h0, 3'b000);
        drain();

        // Random mix against the model
        for (int i = 0; i < 14; i++) begin
            sel = 3'($urandom_range(0, 7));
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            if (i % 4 == 1) b = b >> 28;
            if (i % 5 == 0) b = '0;
            issue_m($sformatf("rnd%0d op%0d s%0d", i, sel, sgn), sel, sgn,
                    a, b);
            drain();
        end

        // Leave nonzero result and flags before the abort
        issue("rem 7%0", 3'b101, 1'b0, 32'h7, 32'h0, 32'h7, 3'b001);
        drain();

        // Reset in the middle of a divide
        issue("div abort", 3'b100, 1'b0, 32'd100, 32'd7, 32'd14, 3'b000);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        sb.delete();
        chk("abort o_valid", W'(o_valid), '0);
        chk("abort o_data", o_data, '0);
        chk("abort flags", W'({ovf, cf, dz}), '0);
        chk("abort i_ready", W'(i_ready), W'(1));
        rst = 1'b0;
        repeat (40) tick();
        issue("add 2+3", 3'b000, 1'b0, 32'd2, 32'd3, 32'd5, 3'b000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
